// File: rtl/edib_m2_frame_rcv.sv
// EDIB M2 receive deframer: sync-word hunt, MSB-first word assembly, bit-clock loss detection.
// Define EDIB_M2_PARITY_EN to expect one odd-parity bit after every data word.
module edib_m2_frame_rcv #(
  parameter logic [15:0] SYNC_WORD       = 16'hEB90,
  parameter int          WORD_BITS       = 16,
  parameter int          WORDS_PER_FRAME = 8,
  parameter int          BIT_TIMEOUT     = 24
) (
  input  logic                 clk_12m,
  input  logic                 reset,
  input  logic                 clk_m2_rcv,
  input  logic                 m2_din,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  output logic [7:0]           word_index,
  output logic                 frame_sync,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt,
  output logic                 clk_lost,
  output logic                 parity_err
);

`ifdef EDIB_M2_PARITY_EN
  localparam int FRAME_BITS = WORD_BITS + 1;
`else
  localparam int FRAME_BITS = WORD_BITS;
`endif
  // The shift register holds every bit of a word except the one arriving on the closing tick.
  localparam int SR_BITS = FRAME_BITS - 1;
  localparam int CNT_W   = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W  = $clog2(BIT_TIMEOUT + 1);

  typedef enum logic {HUNT, DATA} state_t;
  state_t state, state_nxt;

  logic [2:0]           clk_sync;
  logic [1:0]           din_sync;
  logic                 bit_tick, bit_val;
  logic [15:0]          sync_sr, sync_nxt;
  logic [SR_BITS-1:0]   word_sr;
  logic [WORD_BITS-1:0] word_nxt;
  logic                 perr_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [7:0]           word_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 sync_hit, word_end, last_word, timeout;

  // Bit clock and data share the same two-stage delay; the third clock stage only finds the edge.
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      clk_sync <= '0;
      din_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], clk_m2_rcv};
      din_sync <= {din_sync[0], m2_din};
    end
  end

  assign bit_tick  = clk_sync[1] & ~clk_sync[2];
  assign bit_val   = din_sync[1];
  assign sync_nxt  = {sync_sr[14:0], bit_val};
  assign sync_hit  = (state == HUNT) && bit_tick && (sync_nxt == SYNC_WORD);
  assign word_end  = (state == DATA) && bit_tick && (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign last_word = (word_cnt == 8'(WORDS_PER_FRAME - 1));
  assign timeout   = (state == DATA) && !bit_tick && (idle_cnt == IDLE_W'(BIT_TIMEOUT - 1));

`ifdef EDIB_M2_PARITY_EN
  assign word_nxt = word_sr;
  assign perr_nxt = ~(^word_sr ^ bit_val);
`else
  assign word_nxt = {word_sr, bit_val};
  assign perr_nxt = 1'b0;
`endif

  assign frame_sync = (state == DATA);

  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_nxt;
  end

  // NOTE: next-state logic assigns a default before the case so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (sync_hit) state_nxt = DATA;
      DATA:    if ((word_end && last_word) || timeout) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // NOTE: every register here, including the word shift register, is reset so a mid-frame reset leaves no stale data.
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      sync_sr    <= ~SYNC_WORD;
      word_sr    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      idle_cnt   <= '0;
      word_data  <= '0;
      word_index <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      clk_lost   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side sees pre-edge values.
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      clk_lost   <= 1'b0;
      parity_err <= 1'b0;

      if (bit_tick)                             idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(BIT_TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;

      if (state == HUNT) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
        if (bit_tick) sync_sr <= sync_nxt;
      end else if (timeout) begin
        clk_lost <= 1'b1;
        sync_sr  <= ~SYNC_WORD;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (bit_tick) begin
        if (bit_cnt < CNT_W'(SR_BITS)) word_sr <= SR_BITS'({word_sr, bit_val});
        if (word_end) begin
          word_data  <= word_nxt;
          word_index <= word_cnt;
          word_valid <= 1'b1;
          parity_err <= perr_nxt;
          bit_cnt    <= '0;
          if (last_word) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
            sync_sr    <= ~SYNC_WORD;
            word_cnt   <= '0;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule
